// File: rtl/pll_supervisor_if.sv
// Lock/reset handshake and status bundle between pll_supervisor and the PLL wrapper.
interface pll_supervisor_if #(
  parameter int DELAY_WIDTH = 4
);
  logic                   pll_locked;
  logic                   relock;
  logic [DELAY_WIDTH-1:0] delay_init;
  logic                   pll_resetb;
  logic [DELAY_WIDTH-1:0] pll_delay;
  logic                   out_reset;
  logic                   failed;
  logic [2:0]             state;
  logic [7:0]             retries;
  logic [7:0]             loss_count;

  modport slave (
    input  pll_locked, relock, delay_init,
    output pll_resetb, pll_delay, out_reset, failed, state, retries, loss_count
  );

  modport master (
    output pll_locked, relock, delay_init,
    input  pll_resetb, pll_delay, out_reset, failed, state, retries, loss_count
  );
endinterface

// File: rtl/pll_supervisor.sv
// Reference-clock sequencer for an SB_PLL40: reset hold, debounced lock with
// timeout/retry and optional DYNAMICDELAY sweep, downstream reset release.
module pll_supervisor #(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 8,
  parameter int DELAY_WIDTH         = 4,
  parameter bit SWEEP               = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  pll_supervisor_if.slave bus
);
  localparam int MAX_HS  = (RESET_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RESET_HOLD_CYCLES
                                                                    : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (LOCK_TIMEOUT_CYCLES > MAX_HS) ? LOCK_TIMEOUT_CYCLES : MAX_HS;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             retries_q, retries_d;
  logic [7:0]             loss_q, loss_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d;
  logic                   lock_m, lock_s;
  logic                   resetb_q, out_reset_q, failed_q;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    state_d   = state_q;
    retries_d = retries_q;
    loss_d    = loss_q;
    delay_d   = delay_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle takes precedence over the retry.
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retries_d = retries_q + 8'd1;
          if (SWEEP) delay_d = delay_q + DELAY_WIDTH'(1);
          state_d = (retries_d == RETRY_LIMIT) ? S_FAIL : S_HOLD;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = S_RUN;
          retries_d = '0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_HOLD;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_HOLD;
    endcase

    // relock overrides the sequencing but still lets a same-cycle lock loss count.
    if (bus.relock) begin
      state_d   = S_HOLD;
      retries_d = '0;
      delay_d   = bus.delay_init;
    end

    if (state_d != state_q || bus.relock) begin
      cnt_d = '0;
    end else if (state_q inside {S_HOLD, S_WAIT_LOCK, S_STABLE}) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      retries_q   <= '0;
      loss_q      <= '0;
      delay_q     <= bus.delay_init;
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      resetb_q    <= 1'b0;
      out_reset_q <= 1'b1;
      failed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      loss_q      <= loss_d;
      delay_q     <= delay_d;
      lock_m      <= bus.pll_locked;
      lock_s      <= lock_m;
      resetb_q    <= !(state_d inside {S_HOLD, S_FAIL});
      out_reset_q <= (state_d != S_RUN);
      failed_q    <= (state_d == S_FAIL);
    end
  end

  assign bus.state      = state_q;
  assign bus.pll_resetb = resetb_q;
  assign bus.pll_delay  = delay_q;
  assign bus.out_reset  = out_reset_q;
  assign bus.failed     = failed_q;
  assign bus.retries    = retries_q;
  assign bus.loss_count = loss_q;
endmodule

// File: tb/tb_pll_supervisor.sv
// Scenario bench for pll_supervisor: state-transition scoreboard plus inline checks.
`timescale 1ns/1ps
module tb_pll_supervisor;
  localparam int DW = 4;
  localparam logic [2:0] ST_HOLD = 3'd0, ST_WAIT = 3'd1, ST_STABLE = 3'd2,
                         ST_RUN = 3'd3, ST_FAIL = 3'd4;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] dly;
    logic [7:0] rt;
    logic       rb;
    logic       orst;
  } snap_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_fails  = 0;

  snap_t      obs_q[$];
  snap_t      exp_q[$];
  logic [2:0] last_st = 3'h7;

  always #5 clk = ~clk;

  pll_supervisor_if #(.DELAY_WIDTH(DW)) bus_a ();
  pll_supervisor_if #(.DELAY_WIDTH(DW)) bus_b ();

  pll_supervisor #(
    .RESET_HOLD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(16), .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(3), .DELAY_WIDTH(DW), .SWEEP(1'b1)
  ) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a.slave));

  pll_supervisor #(
    .RESET_HOLD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(16), .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(3), .DELAY_WIDTH(DW), .SWEEP(1'b0)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b.slave));

  function automatic snap_t mk(logic [2:0] st, logic [3:0] dly, logic [7:0] rt,
                               logic rb, logic orst);
    snap_t s;
    s.st = st; s.dly = dly; s.rt = rt; s.rb = rb; s.orst = orst;
    return s;
  endfunction

  // Records every state change of dut_a, one step after the edge that caused it.
  always @(posedge clk) begin
    #1;
    if (bus_a.state !== last_st) begin
      obs_q.push_back(mk(bus_a.state, bus_a.pll_delay, bus_a.retries,
                         bus_a.pll_resetb, bus_a.out_reset));
      last_st = bus_a.state;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_a(input logic [2:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_a.state === st) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [25:0] got, req;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.pll_locked = 1'b0; bus_a.relock = 1'b0; bus_a.delay_init = 4'hE;
    bus_b.pll_locked = 1'b0; bus_b.relock = 1'b0; bus_b.delay_init = 4'h5;
    tick(3);
    got = {bus_a.state, bus_a.pll_resetb, bus_a.out_reset, bus_a.failed,
           bus_a.retries, bus_a.loss_count, bus_a.pll_delay};
    req = {ST_HOLD, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'hE};
    n_checks++;
    if (got !== req) begin
      n_fails++;
      $display("FAIL reset_values: got %h required %h", got, req);
    end
  endtask

  task automatic test_first_lock();
    int low, n;
    bit ok;
    rst_a = 1'b0;
    low = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_a.pll_resetb === 1'b0) low++;
      else break;
    end
    n_checks++;
    if (low != 4) begin
      n_fails++;
      $display("FAIL resetb_low_cycles: got %0d required 4", low);
    end
    tick(3);
    bus_a.pll_locked = 1'b1;
    wait_a(ST_STABLE, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL reach_stable: state %0d required %0d", bus_a.state, ST_STABLE);
    end
    n = 0;
    while (bus_a.out_reset !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 8) begin
      n_fails++;
      $display("FAIL stable_to_release: got %0d cycles required 8", n);
    end
    n_checks++;
    if ({bus_a.state, bus_a.retries, bus_a.pll_delay} !== {ST_RUN, 8'd0, 4'hE}) begin
      n_fails++;
      $display("FAIL run_status: st=%0d rt=%0d dly=%h required st=3 rt=0 dly=e",
               bus_a.state, bus_a.retries, bus_a.pll_delay);
    end
  endtask

  task automatic test_lock_loss();
    snap_t e, o;
    bit ok;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back(mk(ST_HOLD,   4'hE, 8'd0, 1'b0, 1'b1));
    exp_q.push_back(mk(ST_WAIT,   4'hE, 8'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(ST_STABLE, 4'hE, 8'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(ST_RUN,    4'hE, 8'd0, 1'b1, 1'b0));
    bus_a.pll_locked = 1'b0;
    tick(2);
    n_checks++;
    if ({bus_a.state, bus_a.out_reset} !== {ST_RUN, 1'b0}) begin
      n_fails++;
      $display("FAIL loss_before_edge: st=%0d out_reset=%b required st=3 out_reset=0",
               bus_a.state, bus_a.out_reset);
    end
    tick();
    n_checks++;
    if ({bus_a.state, bus_a.out_reset, bus_a.loss_count} !== {ST_HOLD, 1'b1, 8'd1}) begin
      n_fails++;
      $display("FAIL loss_edge: st=%0d out_reset=%b loss=%0d required st=0 out_reset=1 loss=1",
               bus_a.state, bus_a.out_reset, bus_a.loss_count);
    end
    bus_a.pll_locked = 1'b1;
    wait_a(ST_RUN, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL resequence_run: state %0d required %0d", bus_a.state, ST_RUN);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_loss[%0d]: no transition seen, required st=%0d", k, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("FAIL sb_loss[%0d]: got st=%0d dly=%h rt=%0d rb=%b orst=%b required st=%0d dly=%h rt=%0d rb=%b orst=%b",
                   k, o.st, o.dly, o.rt, o.rb, o.orst, e.st, e.dly, e.rt, e.rb, e.orst);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fails++;
      $display("FAIL sb_loss_extra: %0d unexpected transitions, required 0", obs_q.size());
    end
  endtask

  task automatic test_relock_with_drop();
    bus_a.delay_init = 4'h3;
    bus_a.pll_locked = 1'b0;
    tick(2);
    bus_a.relock = 1'b1;
    tick();
    bus_a.relock = 1'b0;
    n_checks++;
    if ({bus_a.state, bus_a.loss_count, bus_a.pll_delay, bus_a.out_reset, bus_a.retries} !==
        {ST_HOLD, 8'd2, 4'h3, 1'b1, 8'd0}) begin
      n_fails++;
      $display("FAIL relock_drop: st=%0d loss=%0d dly=%h orst=%b rt=%0d required st=0 loss=2 dly=3 orst=1 rt=0",
               bus_a.state, bus_a.loss_count, bus_a.pll_delay, bus_a.out_reset, bus_a.retries);
    end
    bus_a.delay_init = 4'hE;
  endtask

  task automatic test_timeouts_fail();
    snap_t e, o;
    bit ok;
    bus_a.relock = 1'b1;
    tick();
    bus_a.relock = 1'b0;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back(mk(ST_WAIT, 4'hE, 8'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(ST_HOLD, 4'hF, 8'd1, 1'b0, 1'b1));
    exp_q.push_back(mk(ST_WAIT, 4'hF, 8'd1, 1'b1, 1'b1));
    exp_q.push_back(mk(ST_HOLD, 4'h0, 8'd2, 1'b0, 1'b1));
    exp_q.push_back(mk(ST_WAIT, 4'h0, 8'd2, 1'b1, 1'b1));
    exp_q.push_back(mk(ST_FAIL, 4'h1, 8'd3, 1'b0, 1'b1));
    wait_a(ST_FAIL, 150, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL reach_fail: state %0d required %0d", bus_a.state, ST_FAIL);
    end
    tick(5);
    n_checks++;
    if ({bus_a.state, bus_a.failed, bus_a.retries, bus_a.pll_resetb, bus_a.out_reset} !==
        {ST_FAIL, 1'b1, 8'd3, 1'b0, 1'b1}) begin
      n_fails++;
      $display("FAIL fail_sticky: st=%0d failed=%b rt=%0d rb=%b orst=%b required st=4 failed=1 rt=3 rb=0 orst=1",
               bus_a.state, bus_a.failed, bus_a.retries, bus_a.pll_resetb, bus_a.out_reset);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_timeout[%0d]: no transition seen, required st=%0d", k, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("FAIL sb_timeout[%0d]: got st=%0d dly=%h rt=%0d rb=%b orst=%b required st=%0d dly=%h rt=%0d rb=%b orst=%b",
                   k, o.st, o.dly, o.rt, o.rb, o.orst, e.st, e.dly, e.rt, e.rb, e.orst);
        end
      end
    end
    bus_a.relock = 1'b1;
    tick();
    bus_a.relock = 1'b0;
    n_checks++;
    if ({bus_a.state, bus_a.failed, bus_a.pll_delay, bus_a.retries} !==
        {ST_HOLD, 1'b0, 4'hE, 8'd0}) begin
      n_fails++;
      $display("FAIL relock_from_fail: st=%0d failed=%b dly=%h rt=%0d required st=0 failed=0 dly=e rt=0",
               bus_a.state, bus_a.failed, bus_a.pll_delay, bus_a.retries);
    end
  endtask

  task automatic test_glitch();
    snap_t e, o;
    bit ok;
    int n;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back(mk(ST_WAIT,   4'hE, 8'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(ST_STABLE, 4'hE, 8'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(ST_WAIT,   4'hE, 8'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(ST_STABLE, 4'hE, 8'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(ST_RUN,    4'hE, 8'd0, 1'b1, 1'b0));
    bus_a.pll_locked = 1'b1;
    wait_a(ST_STABLE, 20, ok);
    tick(2);
    bus_a.pll_locked = 1'b0;
    tick();
    bus_a.pll_locked = 1'b1;
    wait_a(ST_WAIT, 10, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL glitch_to_wait: state %0d required %0d", bus_a.state, ST_WAIT);
    end
    wait_a(ST_STABLE, 5, ok);
    n = 0;
    while (bus_a.state !== ST_RUN && n < 30) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 8) begin
      n_fails++;
      $display("FAIL glitch_fresh_stable: got %0d cycles required 8", n);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_glitch[%0d]: no transition seen, required st=%0d", k, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fails++;
          $display("FAIL sb_glitch[%0d]: got st=%0d dly=%h rt=%0d rb=%b orst=%b required st=%0d dly=%h rt=%0d rb=%b orst=%b",
                   k, o.st, o.dly, o.rt, o.rb, o.orst, e.st, e.dly, e.rt, e.rb, e.orst);
        end
      end
    end
  endtask

  task automatic test_loss_saturation();
    int exp_loss;
    bit ok_h, ok_r;
    exp_loss = 2;
    for (int i = 0; i < 256; i++) begin
      bus_a.pll_locked = 1'b0;
      tick();
      bus_a.pll_locked = 1'b1;
      wait_a(ST_HOLD, 5, ok_h);
      wait_a(ST_RUN, 40, ok_r);
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      n_checks++;
      if (!(ok_h && ok_r) || bus_a.loss_count !== 8'(exp_loss)) begin
        n_fails++;
        $display("FAIL loss_count[%0d]: got %0d (hold=%b run=%b) required %0d",
                 i, bus_a.loss_count, ok_h, ok_r, exp_loss);
      end
    end
  endtask

  task automatic test_reset_mid_stable();
    logic [25:0] got, req;
    bit ok;
    bus_a.pll_locked = 1'b0;
    wait_a(ST_HOLD, 5, ok);
    for (int i = 0; i < 40 && bus_a.retries !== 8'd1; i++) tick();
    bus_a.pll_locked = 1'b1;
    wait_a(ST_STABLE, 20, ok);
    tick(3);
    n_checks++;
    if ({ok, bus_a.state, bus_a.retries, bus_a.pll_delay, bus_a.loss_count} !==
        {1'b1, ST_STABLE, 8'd1, 4'hF, 8'd255}) begin
      n_fails++;
      $display("FAIL pre_reset_stable: ok=%b st=%0d rt=%0d dly=%h loss=%0d required ok=1 st=2 rt=1 dly=f loss=255",
               ok, bus_a.state, bus_a.retries, bus_a.pll_delay, bus_a.loss_count);
    end
    rst_a = 1'b1;
    tick();
    got = {bus_a.state, bus_a.pll_resetb, bus_a.out_reset, bus_a.failed,
           bus_a.retries, bus_a.loss_count, bus_a.pll_delay};
    req = {ST_HOLD, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'hE};
    n_checks++;
    if (got !== req) begin
      n_fails++;
      $display("FAIL reset_mid_stable: got %h required %h", got, req);
    end
    rst_a = 1'b0;
  endtask

  task automatic test_no_sweep();
    int max_rt;
    max_rt = 0;
    rst_b = 1'b0;
    for (int i = 0; i < 200 && bus_b.state !== ST_RUN; i++) begin
      n_checks++;
      if (bus_b.pll_delay !== 4'h5) begin
        n_fails++;
        $display("FAIL nosweep_delay[%0d]: got %h required 5", i, bus_b.pll_delay);
      end
      if (int'(bus_b.retries) > max_rt) max_rt = int'(bus_b.retries);
      if (bus_b.retries === 8'd2 && bus_b.state === ST_WAIT) bus_b.pll_locked = 1'b1;
      tick();
    end
    n_checks++;
    if ({bus_b.state, bus_b.retries, bus_b.failed, bus_b.pll_delay} !==
        {ST_RUN, 8'd0, 1'b0, 4'h5} || max_rt != 2) begin
      n_fails++;
      $display("FAIL nosweep_run: st=%0d rt=%0d failed=%b dly=%h max_rt=%0d required st=3 rt=0 failed=0 dly=5 max_rt=2",
               bus_b.state, bus_b.retries, bus_b.failed, bus_b.pll_delay, max_rt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_lock();
    test_lock_loss();
    test_relock_with_drop();
    test_timeouts_fail();
    test_glitch();
    test_loss_saturation();
    test_reset_mid_stable();
    test_no_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Reference-clock-domain sequencer that owns the reset and lock handshake of an iCE40 SB_PLL40 instance (HDMI 250 MHz bit-clock PLL and successors).
- Holds the PLL in reset, waits for a debounced LOCK with timeout and retries, and optionally sweeps the PLL DYNAMICDELAY value on each retry.
- Asserts a downstream reset for the pixel/TMDS logic until lock is stable, and re-sequences automatically on lock loss.
- Instantiated next to the PLL wrapper; its outputs drive the PLL RESETB and DYNAMICDELAY pins and the pixel-domain reset synchroniser.

Parameters:
- RESET_HOLD_CYCLES, 16: cycles pll_resetb is held low per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 4096: cycles allowed from pll_resetb release to first synchronised lock (>=2).
- LOCK_STABLE_CYCLES, 256: consecutive locked cycles required before release (>=1).
- MAX_RETRIES, 8: timeouts tolerated before FAIL (1..255).
- DELAY_WIDTH, 4: width of the dynamic delay code.
- SWEEP, 1: 1 = advance delay code on each timeout; 0 = delay code fixed at delay_init.

Ports:
- clk  in  1  reference clock (PLL input clock).
- reset  in  1  synchronous, active-high.
- pll_locked  in  1  raw PLL LOCK, asynchronous; 2-FF synchronised internally (lock_s).
- relock  in  1  single-cycle request to restart sequencing.
- delay_init  in  DELAY_WIDTH  delay code loaded at reset and on relock.
- pll_resetb  out  1  to PLL RESETB, active-low.
- pll_delay  out  DELAY_WIDTH  to PLL DYNAMICDELAY field.
- out_reset  out  1  downstream reset, active-high.
- failed  out  1  sticky failure flag.
- state  out  3  HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- retries  out  8  timeouts in current sequence.
- loss_count  out  8  lock losses from RUN, saturating at 255.

Behaviour:
- All outputs registered; reset to state=HOLD, pll_resetb=0, out_reset=1, failed=0, retries=0, loss_count=0, pll_delay=delay_init, cycle counter=0, sync flops=0.
- Cycle counter: width $clog2 of the largest cycle parameter + 1; cleared on every state change.
- HOLD: pll_resetb=0, out_reset=1. After exactly RESET_HOLD_CYCLES cycles in HOLD -> WAIT_LOCK; pll_resetb=1 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0 -> timeout. retries+1; if SWEEP, pll_delay+1 (wraps modulo 2^DELAY_WIDTH).
  - If the new retries equals MAX_RETRIES -> FAIL, otherwise -> HOLD.
- STABLE:
  - lock_s=0 -> WAIT_LOCK; counter cleared; not a retry, timeout restarts.
  - LOCK_STABLE_CYCLES consecutive cycles with lock_s=1 -> RUN; retries cleared.
- RUN: out_reset=0 from the first RUN cycle. lock_s=0 -> HOLD with out_reset=1 on the same edge; loss_count+1, saturating; pll_delay unchanged.
- FAIL: failed=1, pll_resetb=0, out_reset=1. Exits only via reset or relock.
- relock, any state, highest priority:
  - Next state HOLD; counter=0, retries=0, failed=0, pll_delay=delay_init.
  - A lock loss from RUN in the same cycle is still counted in loss_count.
- Timeout and lock_s rising in the same cycle: lock wins -> STABLE.
- Latency: a raw pll_locked edge is visible on lock_s 2 cycles later. Best-case reset-to-release = RESET_HOLD_CYCLES + 2 + LOCK_STABLE_CYCLES cycles, ±1 for the sampling edge.
- out_reset is never 0 outside RUN; pll_resetb is 0 only in HOLD and FAIL.

Test Plan:
- Bench parameters: RESET_HOLD=4, TIMEOUT=16, STABLE=8, MAX_RETRIES=3, DELAY_WIDTH=4, SWEEP=1, delay_init=4'hE.
- Lock high 3 cycles after pll_resetb rises -> pll_resetb low exactly 4 cycles; STABLE after lock_s; out_reset falls 8 cycles later; retries=0; pll_delay=0xE.
- Lock never asserts -> after 3 timeouts: pll_delay sequence E, F, 0 then FAIL; failed=1, retries=3, pll_resetb=0. relock pulse -> HOLD, failed=0, pll_delay=0xE.
- Lock glitch low for 1 cycle at cycle 5 of STABLE -> return to WAIT_LOCK; RUN only after 8 fresh consecutive locked cycles; retries unchanged.
- Lock drop in RUN -> out_reset=1 on the transition edge, loss_count 0->1, full re-sequence back to RUN. Force 256 losses -> loss_count holds 255.
- relock asserted in the same cycle as a lock drop in RUN -> HOLD, loss_count+1, pll_delay=delay_init. Reset asserted mid-STABLE -> all outputs at reset values on the next edge.
- SWEEP=0 with 2 timeouts then lock -> pll_delay stays delay_init throughout.
